// File: rtl/ypc_pkg.sv
// Shared state encoding and constants for the YPC multi-cycle sequencer.
package ypc_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } seq_state_e;

  // Counters only advance while an instruction is in flight.
  function automatic logic is_running(input seq_state_e s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) || (s == S_WB);
  endfunction

endpackage

// File: rtl/ypc_seq_ctrl_if.sv
// Instruction-memory request/acknowledge channel between the sequencer and imem.
interface ypc_seq_ctrl_if #(
  parameter int ADDR_W = 32
);
  import ypc_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_inst;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_inst
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_inst
  );

endinterface

// File: rtl/ypc_perf_cnt.sv
// Cycle and retired-instruction counters; both wrap silently at 2^CNT_W.
module ypc_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_o
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (run_i) cycle_d = cycle_q + CNT_W'(1);
    if (inc_i) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o = cycle_q;
  assign instret_o   = instret_q;

endmodule

// File: rtl/ypc_seq_ctrl.sv
// FETCH/DECODE/EXEC/WB sequencer for the YPC core: owns PC, IR, halt/fault status
// and gates the ALU latch and register-file write strobes.
module ypc_seq_ctrl
  import ypc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  ypc_seq_ctrl_if.master    imem,
  output logic [INST_W-1:0] ir,
  input  logic              dec_isbreak,
  input  logic              dec_illegal,
  input  logic              dec_regwen,
  output logic              alu_en,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] pc,
  output logic              halt,
  output logic              fault,
  output logic              sim_end,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [15:0]       wait_q, wait_d;
  logic              sim_end_q, sim_end_d;
  logic              fetch_done;
  logic              retire;

  // Request is gated by reset so an outstanding fetch drops as soon as reset rises.
  assign imem.imem_req  = (state_q == S_FETCH) && !reset;
  assign imem.imem_addr = pc_q;
  assign fetch_done     = imem.imem_req && imem.imem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wait_q    <= '0;
      sim_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      sim_end_q <= sim_end_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    sim_end_d = 1'b0;
    retire    = 1'b0;
    alu_en    = 1'b0;
    rf_wen    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (fetch_done) begin
          ir_d    = imem.imem_inst;
          wait_d  = '0;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (dec_isbreak) begin
          // ebreak counts as retired even though it never reaches WB.
          state_d   = S_HALT;
          sim_end_d = 1'b1;
          retire    = 1'b1;
        end else if (dec_illegal) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        rf_wen  = dec_regwen;
        pc_d    = pc_q + ADDR_W'(PC_STEP);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  ypc_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .reset      (reset),
    .run_i      (is_running(state_q)),
    .inc_i      (retire),
    .cycle_cnt_o(cycle_cnt),
    .instret_o  (instret)
  );

  assign ir      = ir_q;
  assign pc      = pc_q;
  assign halt    = (state_q == S_HALT) || (state_q == S_FAULT);
  assign fault   = (state_q == S_FAULT);
  assign sim_end = sim_end_q;

endmodule

// File: doc/ypc_seq_ctrl.md
Name: ypc_seq_ctrl

Overview:
Multi-cycle sequencer for the YPC core.
- Replaces free-running per-clock PC increment with an explicit FETCH/DECODE/EXEC/WB state machine.
- Instruction memory is reached through a req/ack handshake; the fetched instruction is latched into an instruction register.
- Gates the register-file write port and ALU result latch.
- Owns the PC, halt/fault status and performance counters.

Parameters:
ADDR_W, 32, PC and instruction address width
RESET_PC, 32'h0, PC value loaded on reset
TIMEOUT, 16, FETCH wait cycles without ack before fault (1..65535)
CNT_W, 32, width of cycle/instret counters

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  fetch address; equals pc
imem_ack  in  1  instruction valid this cycle; qualified by imem_req
imem_inst  in  32  instruction word, sampled when req&&ack
ir  out  32  latched instruction, feeds decoder
dec_isbreak  in  1  decoder: ir is ebreak
dec_illegal  in  1  decoder: ir unsupported
dec_regwen  in  1  decoder: ir writes rd
alu_en  out  1  one-cycle strobe: latch ALU result
rf_wen  out  1  one-cycle register-file write enable
pc  out  ADDR_W  current instruction address
halt  out  1  sticky: ebreak retired or fault
fault  out  1  sticky: illegal instruction or fetch timeout
sim_end  out  1  one-cycle pulse on entry to HALT, drives End_Sim DPI
cycle_cnt  out  CNT_W  cycles since reset while running
instret  out  CNT_W  retired instructions

Behaviour:
Clocking and reset
- Single clock domain; reset is asynchronous and active-high, port named reset.
- While reset is high:
  - state=FETCH, pc=RESET_PC, ir=0, wait counter=0.
  - All other outputs are 0: imem_req, alu_en, rf_wen, halt, fault, sim_end, cycle_cnt, instret.
- Reset asserted mid-operation (any state, including an outstanding fetch) drops imem_req combinationally via the async clear. No write is completed.

States: FETCH, DECODE, EXEC, WB, HALT, FAULT. Encoding is 3 bits and lives in the package.
- FETCH
  - imem_req=1, imem_addr=pc.
  - On req&&ack: ir<=imem_inst, wait counter cleared, go DECODE. Ack in the first FETCH cycle is legal.
  - Otherwise the wait counter increments. When it reaches TIMEOUT-1 with no ack, go FAULT.
- DECODE
  - Decoder outputs are combinational from ir.
  - Priority: dec_isbreak -> HALT; else dec_illegal -> FAULT; else -> EXEC.
- EXEC: alu_en=1 for exactly this cycle; go WB.
- WB
  - rf_wen=dec_regwen for exactly this cycle.
  - pc<=pc+4, modulo 2^ADDR_W, wraps silently.
  - instret+=1; go FETCH.
- HALT
  - halt=1 and sticky.
  - sim_end=1 only in the first HALT cycle.
  - pc holds at the ebreak address.
  - ebreak increments instret on the DECODE->HALT transition.
  - Exits only on reset.
- FAULT
  - fault=1 and halt=1, both sticky.
  - pc holds at the offending address; no sim_end.
  - Exits only on reset.

Counters and handshake
- cycle_cnt increments every cycle in FETCH/DECODE/EXEC/WB and freezes in HALT/FAULT.
- cycle_cnt and instret wrap modulo 2^CNT_W.
- imem_ack outside FETCH is ignored; no state change, ir unchanged.
- rf_wen and alu_en are never high outside WB and EXEC respectively, and never simultaneously.
- Minimum latency is 4 cycles per instruction (zero-wait memory). Each cycle of memory wait adds 1.

Decomposition:
- Package ypc_pkg holds:
  - state enum/localparams (FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4, FAULT=5)
  - PC_STEP=4
  - instruction width 32
- One sub-module, ypc_perf_cnt: cycle_cnt and instret counters with run/inc enables, parameterised by CNT_W.
- FSM, PC and ir stay in ypc_seq_ctrl.

Test Plan:
- Zero-wait memory, program addi,addi,ebreak from 0x0:
  - pc steps 0x0 -> 0x4 -> 0x8.
  - rf_wen pulses at cycles 4 and 8.
  - sim_end pulses once at cycle 11.
  - instret=3, cycle_cnt=10, halt=1 and stays 1 for 20 further cycles.
- Ack delayed 3 cycles on second fetch:
  - imem_req held 4 cycles at imem_addr=0x4.
  - ir updates only on the ack cycle.
  - cycle_cnt for that instruction is 7.
- TIMEOUT=16, ack never returns:
  - fault=1 and halt=1 after exactly 16 FETCH cycles.
  - sim_end stays 0; pc=0x0; rf_wen never asserted.
- Illegal instruction at 0x8: FAULT entered from DECODE, pc=0x8, instret=2, no alu_en or rf_wen for that word.
- Reset asserted mid-FETCH and mid-EXEC:
  - outputs clear asynchronously, before the next clk edge.
  - restart from RESET_PC=0x80000000 with cycle_cnt=0.
- Wrap cases:
  - RESET_PC=0xFFFFFFFC with a non-break instruction: pc becomes 0x0 after WB.
  - CNT_W=4, 17 instructions: instret reads 1.
